// File: rtl/dds_measure.sv
// Waveform measurement: hysteresis comparator around an adaptive mid-level, reporting
// period, high time and peaks per cycle. Define DDS_MEASURE_AVG_EN to average over 4 periods.
module dds_measure #(
    parameter logic [15:0] HYST    = 16'd256,
    parameter logic [31:0] TIMEOUT = 32'd16777216
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    output logic [31:0] period,
    output logic [31:0] high_time,
    output logic [15:0] peak_max,
    output logic [15:0] peak_min,
    output logic        result_valid,
    output logic        no_signal
);
    typedef enum logic [1:0] {SEEK, LOW, HIGH} state_t;
    state_t state, state_nxt;

    logic [15:0] mid, hi_th, lo_th;
    logic [15:0] trk_max, trk_min, cur_max, cur_min, mid_new;
    logic [16:0] hi_sum, pk_sum;
    logic [31:0] cnt, ht_cap, per_res, ht_res;
    logic        armed, rise, fall, timeout, publish, reload;

    assign hi_sum = {1'b0, mid} + {1'b0, HYST};
    assign hi_th  = hi_sum[16] ? 16'hFFFF : hi_sum[15:0];
    assign lo_th  = (mid >= HYST) ? (mid - HYST) : 16'h0000;

    // Trackers including the current sample; these are what a rising crossing publishes.
    assign cur_max = (sample_valid && sample > trk_max) ? sample : trk_max;
    assign cur_min = (sample_valid && sample < trk_min) ? sample : trk_min;
    assign pk_sum  = {1'b0, cur_max} + {1'b0, cur_min};
    assign mid_new = pk_sum[16:1];

    always_comb begin
        state_nxt = state;
        rise      = 1'b0;
        fall      = 1'b0;
        timeout   = 1'b0;
        if (sample_valid) begin
            case (state)
                SEEK: if (sample <= lo_th) state_nxt = LOW;
                LOW: begin
                    if (sample >= hi_th) begin
                        rise      = 1'b1;
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (sample <= lo_th) begin
                        fall      = 1'b1;
                        state_nxt = LOW;
                    end
                end
                default: state_nxt = SEEK;
            endcase
        end
        // Fires once, on the cycle cnt steps onto TIMEOUT; a crossing in that cycle wins.
        if (!rise && cnt == TIMEOUT - 32'd1) begin
            timeout   = 1'b1;
            state_nxt = SEEK;
        end
    end

`ifdef DDS_MEASURE_AVG_EN
    logic [1:0]  avg_cnt;
    logic [33:0] per_acc, ht_acc, per_sum, ht_sum;

    assign per_sum = per_acc + {2'b00, cnt};
    assign ht_sum  = ht_acc + {2'b00, ht_cap};
    assign publish = rise && armed && (avg_cnt == 2'd3);
    // Trackers span the whole 4-period window, so only restart them at a window boundary.
    assign reload  = rise && (!armed || avg_cnt == 2'd3);
    assign per_res = per_sum[33:2];
    assign ht_res  = ht_sum[33:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg_cnt <= 2'd0;
            per_acc <= '0;
            ht_acc  <= '0;
        end else if (rise && armed) begin
            if (publish) begin
                avg_cnt <= 2'd0;
                per_acc <= '0;
                ht_acc  <= '0;
            end else begin
                avg_cnt <= avg_cnt + 2'd1;
                per_acc <= per_sum;
                ht_acc  <= ht_sum;
            end
        end else if (timeout) begin
            avg_cnt <= 2'd0;
            per_acc <= '0;
            ht_acc  <= '0;
        end
    end
`else
    assign publish = rise && armed;
    assign reload  = rise;
    assign per_res = cnt;
    assign ht_res  = ht_cap;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SEEK;
            cnt          <= '0;
            ht_cap       <= '0;
            armed        <= 1'b0;
            mid          <= 16'h8000;
            trk_max      <= 16'h0000;
            trk_min      <= 16'hFFFF;
            period       <= '0;
            high_time    <= '0;
            peak_max     <= 16'h0000;
            peak_min     <= 16'hFFFF;
            result_valid <= 1'b0;
            no_signal    <= 1'b0;
        end else begin
            state        <= state_nxt;
            result_valid <= publish;

            if (rise)                cnt <= 32'd1;
            else if (cnt != TIMEOUT) cnt <= cnt + 32'd1;

            if (fall) ht_cap <= cnt;

            if (reload) begin
                trk_max <= sample;
                trk_min <= sample;
            end else if (sample_valid) begin
                trk_max <= cur_max;
                trk_min <= cur_min;
            end

            if (rise) armed <= 1'b1;

            if (publish) begin
                period    <= per_res;
                high_time <= ht_res;
                peak_max  <= cur_max;
                peak_min  <= cur_min;
                mid       <= mid_new;
                no_signal <= 1'b0;
            end

            if (timeout) begin
                no_signal <= 1'b1;
                armed     <= 1'b0;
                mid       <= 16'h8000;
            end
        end
    end
endmodule

// File: tb/tb_dds_measure.sv
// Directed bench for dds_measure: expected results are queued as stimulus is driven
// and popped whenever result_valid pulses.
module tb_dds_measure;
    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample;
    logic [31:0] period, high_time;
    logic [15:0] peak_max, peak_min;
    logic        result_valid, no_signal;

    typedef struct {
        logic [31:0] per;
        logic [31:0] ht;
        logic [15:0] mx;
        logic [15:0] mn;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dds_measure #(.HYST(16'd256), .TIMEOUT(32'd1000)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .period(period), .high_time(high_time), .peak_max(peak_max), .peak_min(peak_min),
        .result_valid(result_valid), .no_signal(no_signal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_period"}, period, 32'd0);
        chk({tag, "_high_time"}, high_time, 32'd0);
        chk({tag, "_peak_max"}, {16'd0, peak_max}, 32'h0);
        chk({tag, "_peak_min"}, {16'd0, peak_min}, 32'hFFFF);
        chk({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
        chk({tag, "_no_signal"}, {31'd0, no_signal}, 32'd0);
    endtask

    task automatic expect_res(input int p, input int h, input logic [15:0] mx, input logic [15:0] mn);
        res_t r;
        r.per = p;
        r.ht  = h;
        r.mx  = mx;
        r.mn  = mn;
        exp_q.push_back(r);
    endtask

    // One clock with the given inputs; a result_valid pulse is matched against the queue.
    task automatic tick(input logic v, input logic [15:0] s);
        res_t r;
        sample_valid = v;
        sample       = s;
        @(posedge clk);
        #1;
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result_valid", exp_q.size(), 32'd1);
            end else begin
                r = exp_q.pop_front();
                chk("period", period, r.per);
                chk("high_time", high_time, r.ht);
                chk("peak_max", {16'd0, peak_max}, {16'd0, r.mx});
                chk("peak_min", {16'd0, peak_min}, {16'd0, r.mn});
            end
        end
    endtask

    // One waveform cycle: nh high samples then nl low samples, one strobe every 'stride' clocks.
    task automatic cyc(input logic [15:0] hv, input logic [15:0] lv, input int nh, input int nl,
                       input int stride, input bit glitch);
        for (int i = 0; i < nh + nl; i++) begin
            logic [15:0] s;
            s = (i < nh) ? hv : lv;
            if (glitch && i == 2)      s = 16'h1F38;
            if (glitch && i == nh + 3) s = 16'h20C8;
            tick(1'b1, s);
            for (int k = 1; k < stride; k++) tick(1'b0, s);
        end
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample       = 16'h0000;
        #12;
        chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

`ifdef DDS_MEASURE_AVG_EN
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        cyc(16'hFFFF, 16'h0000, 30, 72, 1, 1'b0);
        cyc(16'hFFFF, 16'h0000, 30, 68, 1, 1'b0);
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        expect_res(100, 30, 16'hFFFF, 16'h0000);
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        chk("avg_period_hold", period, 32'd100);
`else
        // Square wave 30 high / 70 low, strobe every clock.
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        expect_res(100, 30, 16'hFFFF, 16'h0000);
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        expect_res(100, 30, 16'hFFFF, 16'h0000);
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        chk("mid_square", {16'd0, dut.mid}, 32'h7FFF);
        chk("period_hold", period, 32'd100);

        // Reset while HIGH, then the first result needs two rising crossings.
        expect_res(100, 30, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 10; i++) tick(1'b1, 16'hFFFF);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("rst_high");
        chk("state_seek", 32'(dut.state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        expect_res(100, 30, 16'hFFFF, 16'h0000);
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);

        // Walk mid down to 0x2000 so a 0x1000/0x3000 wave crosses, strobe every 4 clocks.
        expect_res(100, 30, 16'hFFFF, 16'h0000);
        cyc(16'h80FF, 16'h1000, 4, 8, 4, 1'b0);
        expect_res(48, 16, 16'h80FF, 16'h1000);
        cyc(16'h80FF, 16'h1000, 4, 8, 4, 1'b0);
        chk("mid_step1", {16'd0, dut.mid}, 32'h487F);
        expect_res(48, 16, 16'h80FF, 16'h1000);
        cyc(16'h497F, 16'h1000, 4, 8, 4, 1'b0);
        expect_res(48, 16, 16'h497F, 16'h1000);
        cyc(16'h497F, 16'h1000, 4, 8, 4, 1'b0);
        chk("mid_step2", {16'd0, dut.mid}, 32'h2CBF);
        expect_res(48, 16, 16'h497F, 16'h1000);
        cyc(16'h3000, 16'h1000, 4, 8, 4, 1'b0);
        expect_res(48, 16, 16'h3000, 16'h1000);
        cyc(16'h3000, 16'h1000, 4, 8, 4, 1'b0);
        chk("mid_step3", {16'd0, dut.mid}, 32'h2000);

        // In-band glitches must neither cross nor disturb the period.
        expect_res(48, 16, 16'h3000, 16'h1000);
        cyc(16'h3000, 16'h1000, 4, 8, 4, 1'b1);
        expect_res(48, 16, 16'h3000, 16'h1000);
        cyc(16'h3000, 16'h1000, 4, 8, 4, 1'b1);
        expect_res(48, 16, 16'h3000, 16'h1000);
        cyc(16'h3000, 16'h1000, 4, 8, 4, 1'b0);

        // Constant input: cnt is 48 here, so timeout lands 952 clocks later.
        for (int i = 0; i < 951; i++) tick(1'b1, 16'h1234);
        chk("no_signal_before", {31'd0, no_signal}, 32'd0);
        tick(1'b1, 16'h1234);
        chk("no_signal_set", {31'd0, no_signal}, 32'd1);
        chk("timeout_mid", {16'd0, dut.mid}, 32'h8000);
        chk("timeout_period_hold", period, 32'd48);
        chk("timeout_peak_hold", {16'd0, peak_max}, 32'h3000);
        for (int i = 0; i < 20; i++) tick(1'b1, 16'h1234);
        chk("no_signal_level", {31'd0, no_signal}, 32'd1);

        // Recovery: re-arm on one crossing, publish on the next.
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        chk("no_signal_after_arm", {31'd0, no_signal}, 32'd1);
        expect_res(100, 30, 16'hFFFF, 16'h0000);
        cyc(16'hFFFF, 16'h0000, 30, 70, 1, 1'b0);
        chk("no_signal_cleared", {31'd0, no_signal}, 32'd0);
`endif

        chk("results_pending", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
